controller_fsm: RTL
===================

Name: controller_fsm

Overview:
- Parametrised multicycle control unit for the accumulator CPU. It drives the datapath register loads, PC source, ALU operation and memory strobes.
- Successor to the fixed 3-register, zero-wait controller. Adds:
  - register count generalised through a parameter
  - a memory wait handshake (mem_ready)
  - register-indirect conditional jumps
  - logic ALU ops and jump-on-overflow
  - HALT, plus a sticky illegal-instruction trap
- Sits between the instruction register and the datapath/memory muxes.

Parameters:
- INST_SIZE, 6, opcode width
- REG_ADDR_SIZE, 4, register-field width
- NUM_REGS, 3, number of loadable datapath registers (index 0=alu1, 1=alu2, 2=acc, higher=general); must be ≤ 2^REG_ADDR_SIZE
- ALU_OP_SIZE, 3, alu_operation width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  INST_SIZE  opcode field from IR
- register  in  REG_ADDR_SIZE  register field from IR
- alu_zero  in  1  accumulator == 0
- alu_overflow  in  1  ALU overflow for the current operation
- mem_ready  in  1  memory completes the current read/write this cycle
- ld_reg  out  NUM_REGS  one-hot load strobe, register index i
- reg_src_sel  out  2  data source for loaded register: 00 ALU result, 10 memory
- reg_out_sel  out  REG_ADDR_SIZE  register driving memory data / PC indirect source
- ld_ir  out  1  load IR from memory
- ld_pc  out  1  load PC
- pc_src  out  2  00 PC+1, 01 immediate address, 10 acc, 11 register selected by reg_out_sel
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_addr_sel  out  2  00 none, 01 IR immediate, 10 PC
- alu_operation  out  ALU_OP_SIZE  000 add, 001 sub, 010 and, 011 or, 100 xor
- halted  out  1  core stopped (HALT or illegal)
- illegal  out  1  sticky illegal-instruction flag
- state  out  3  current state encoding, for debug

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - State register encoding: RESET=000, FETCH=001, DECODE=010, EXECUTE=011, HALT=100.
  - reset=1 at an edge: state←RESET, illegal←0, ovf_flag←0, from any state including mid-wait.
  - While reset=1, every strobe (ld_*, mem_*) is forced to 0 combinationally. All other outputs are 0 in RESET.
- Outputs are combinational from state, opcode, register, flags and mem_ready. Unlisted outputs are 0.
- State transitions:
  - RESET → FETCH on the first edge with reset=0.
  - FETCH: mem_addr_sel=10, mem_read=1. When mem_ready=1: ld_ir=1 and go to DECODE. Otherwise hold in FETCH.
  - DECODE: no strobes; always go to EXECUTE. An opcode is illegal if it is undefined, or if it needs a register and register ≥ NUM_REGS.
  - EXECUTE: performs the opcode below. ld_pc is asserted exactly once per instruction, in the final EXECUTE cycle; pc_src=00 unless stated. Then go to FETCH.
- Opcodes (hex):
  - 00 NOP.
  - 01 LOAD: mem_addr_sel=01, mem_read=1, reg_src_sel=10. When mem_ready: ld_reg[register]=1 and ld_pc=1. Otherwise hold in EXECUTE.
  - 02 STORE: mem_addr_sel=01, mem_write=1, reg_out_sel=register. When mem_ready: ld_pc=1. Otherwise hold.
  - 03 JMPI: pc_src=01.
  - 04 JMP: pc_src=10.
  - 05 JZI: pc_src = alu_zero ? 01 : 00.
  - 06 JZ: pc_src = alu_zero ? 11 : 00; reg_out_sel=register.
  - 07 JNZI: pc_src = alu_zero ? 00 : 01.
  - 08 JNZ: pc_src = alu_zero ? 00 : 11; reg_out_sel=register.
  - 09–0D ADD/SUB/AND/OR/XOR: alu_operation = opcode−9; reg_src_sel=00; ld_reg[2]=1. For ADD/SUB only, ovf_flag←alu_overflow.
  - 0E JOI: pc_src = ovf_flag ? 01 : 00; ovf_flag←0.
  - 3F HALT: no ld_pc; go to HALT.
  - Illegal: no strobes, no ld_pc; illegal←1; go to HALT.
- HALT: all strobes 0, halted=1. Exit only via reset.
- Latency with mem_ready tied 1: 3 cycles per instruction. Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH and LOAD/STORE EXECUTE.

Test Plan:
- Reset held 2 cycles then released, mem_ready=1, IR=NOP → state 000,001,010,011,001. ld_ir=1 in FETCH, ld_pc=1 with pc_src=00 in EXECUTE only.
- LOAD register=1 with mem_ready low for 2 EXECUTE cycles → mem_read=1 for 3 cycles; ld_reg=010 and ld_pc=1 only in the 3rd cycle; then FETCH.
- ADD with alu_overflow=1, then JOI → ld_reg=100, alu_operation=000; JOI gives pc_src=01; a second JOI gives pc_src=00.
- JNZ register=2 with alu_zero=0 → pc_src=11, reg_out_sel=2, ld_pc=1. Same instruction with alu_zero=1 → pc_src=00.
- Opcode 0x20, and separately LOAD register=5 (NUM_REGS=3) → no strobes in EXECUTE; illegal=1 and halted=1 thereafter; no further ld_ir until reset clears both.
- Reset asserted during a STORE wait → mem_write drops to 0 in the same cycle; state=RESET after the edge; illegal=0.

Source files
------------

// File: rtl/controller_fsm.sv
// Multicycle control unit for the accumulator CPU.
// Sequences FETCH -> DECODE -> EXECUTE and drives the datapath register
// loads, PC source, ALU operation and memory strobes. Memory accesses wait
// on mem_ready. HALT and illegal instructions park the core until reset.
module controller_fsm #(
  parameter int INST_SIZE     = 6,
  parameter int REG_ADDR_SIZE = 4,
  parameter int NUM_REGS      = 3,
  parameter int ALU_OP_SIZE   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [INST_SIZE-1:0]     opcode,
  input  logic [REG_ADDR_SIZE-1:0] register,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,
  input  logic                     mem_ready,
  output logic [NUM_REGS-1:0]      ld_reg,
  output logic [1:0]               reg_src_sel,
  output logic [REG_ADDR_SIZE-1:0] reg_out_sel,
  output logic                     ld_ir,
  output logic                     ld_pc,
  output logic [1:0]               pc_src,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [1:0]               mem_addr_sel,
  output logic [ALU_OP_SIZE-1:0]   alu_operation,
  output logic                     halted,
  output logic                     illegal,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_RESET   = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_EXECUTE = 3'b011,
    S_HALT    = 3'b100
  } state_t;

  localparam logic [INST_SIZE-1:0] OP_NOP   = INST_SIZE'('h00);
  localparam logic [INST_SIZE-1:0] OP_LOAD  = INST_SIZE'('h01);
  localparam logic [INST_SIZE-1:0] OP_STORE = INST_SIZE'('h02);
  localparam logic [INST_SIZE-1:0] OP_JMPI  = INST_SIZE'('h03);
  localparam logic [INST_SIZE-1:0] OP_JMP   = INST_SIZE'('h04);
  localparam logic [INST_SIZE-1:0] OP_JZI   = INST_SIZE'('h05);
  localparam logic [INST_SIZE-1:0] OP_JZ    = INST_SIZE'('h06);
  localparam logic [INST_SIZE-1:0] OP_JNZI  = INST_SIZE'('h07);
  localparam logic [INST_SIZE-1:0] OP_JNZ   = INST_SIZE'('h08);
  localparam logic [INST_SIZE-1:0] OP_ADD   = INST_SIZE'('h09);
  localparam logic [INST_SIZE-1:0] OP_SUB   = INST_SIZE'('h0A);
  localparam logic [INST_SIZE-1:0] OP_AND   = INST_SIZE'('h0B);
  localparam logic [INST_SIZE-1:0] OP_OR    = INST_SIZE'('h0C);
  localparam logic [INST_SIZE-1:0] OP_XOR   = INST_SIZE'('h0D);
  localparam logic [INST_SIZE-1:0] OP_JOI   = INST_SIZE'('h0E);
  localparam logic [INST_SIZE-1:0] OP_HALT  = INST_SIZE'('h3F);

  // Accumulator is datapath register index 2.
  localparam int ACC_IDX = 2;

  state_t state_q;
  logic   illegal_q;
  logic   ovf_flag;

  logic                is_defined;
  logic                needs_reg;
  logic                reg_out_of_range;
  logic                op_illegal;
  logic [NUM_REGS-1:0] reg_onehot;
  logic [NUM_REGS-1:0] acc_onehot;

  // Classify the current opcode: defined or not, and whether its register field must be valid.
  always_comb begin
    is_defined = 1'b0;
    needs_reg  = 1'b0;
    case (opcode)
      OP_NOP, OP_JMPI, OP_JMP, OP_JZI, OP_JNZI,
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_JOI, OP_HALT: begin
        is_defined = 1'b1;
      end
      OP_LOAD, OP_STORE, OP_JZ, OP_JNZ: begin
        is_defined = 1'b1;
        needs_reg  = 1'b1;
      end
      default: begin
        is_defined = 1'b0;
      end
    endcase
    // Widen by one bit so NUM_REGS == 2**REG_ADDR_SIZE does not wrap to zero.
    reg_out_of_range = ({1'b0, register} >= (REG_ADDR_SIZE + 1)'(NUM_REGS));
    op_illegal       = !is_defined || (needs_reg && reg_out_of_range);
  end

  // One-hot load masks for the addressed register and for the accumulator.
  always_comb begin
    reg_onehot = '0;
    acc_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_onehot[i] = (register == REG_ADDR_SIZE'(i));
      acc_onehot[i] = (i == ACC_IDX);
    end
  end

  // State, sticky illegal flag and overflow flag for jump-on-overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (op_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            case (opcode)
              OP_LOAD, OP_STORE: begin
                if (mem_ready) begin
                  state_q <= S_FETCH;
                end
              end
              OP_HALT: begin
                state_q <= S_HALT;
              end
              OP_ADD, OP_SUB: begin
                ovf_flag <= alu_overflow;
                state_q  <= S_FETCH;
              end
              OP_JOI: begin
                ovf_flag <= 1'b0;
                state_q  <= S_FETCH;
              end
              default: begin
                state_q <= S_FETCH;
              end
            endcase
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

  // Datapath and memory controls decoded from state, opcode and flags.
  always_comb begin
    ld_reg        = '0;
    reg_src_sel   = 2'b00;
    reg_out_sel   = '0;
    ld_ir         = 1'b0;
    ld_pc         = 1'b0;
    pc_src        = 2'b00;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 2'b00;
    alu_operation = '0;

    case (state_q)
      S_FETCH: begin
        mem_addr_sel = 2'b10;
        mem_read     = 1'b1;
        ld_ir        = mem_ready;
      end
      S_EXECUTE: begin
        if (!op_illegal) begin
          case (opcode)
            OP_NOP: begin
              ld_pc = 1'b1;
            end
            OP_LOAD: begin
              mem_addr_sel = 2'b01;
              mem_read     = 1'b1;
              reg_src_sel  = 2'b10;
              if (mem_ready) begin
                ld_reg = reg_onehot;
                ld_pc  = 1'b1;
              end
            end
            OP_STORE: begin
              mem_addr_sel = 2'b01;
              mem_write    = 1'b1;
              reg_out_sel  = register;
              ld_pc        = mem_ready;
            end
            OP_JMPI: begin
              ld_pc  = 1'b1;
              pc_src = 2'b01;
            end
            OP_JMP: begin
              ld_pc  = 1'b1;
              pc_src = 2'b10;
            end
            OP_JZI: begin
              ld_pc  = 1'b1;
              pc_src = alu_zero ? 2'b01 : 2'b00;
            end
            OP_JZ: begin
              ld_pc       = 1'b1;
              reg_out_sel = register;
              pc_src      = alu_zero ? 2'b11 : 2'b00;
            end
            OP_JNZI: begin
              ld_pc  = 1'b1;
              pc_src = alu_zero ? 2'b00 : 2'b01;
            end
            OP_JNZ: begin
              ld_pc       = 1'b1;
              reg_out_sel = register;
              pc_src      = alu_zero ? 2'b00 : 2'b11;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              alu_operation = ALU_OP_SIZE'(opcode - OP_ADD);
              reg_src_sel   = 2'b00;
              ld_reg        = acc_onehot;
              ld_pc         = 1'b1;
            end
            OP_JOI: begin
              ld_pc  = 1'b1;
              pc_src = ovf_flag ? 2'b01 : 2'b00;
            end
            default: begin
              ld_pc = 1'b0;
            end
          endcase
        end
      end
      default: begin
        ld_pc = 1'b0;
      end
    endcase

    // Strobes must not fire while reset is held, even mid-access.
    if (reset) begin
      ld_reg       = '0;
      ld_ir        = 1'b0;
      ld_pc        = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr_sel = 2'b00;
    end
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
